// File: rtl/fan_mode_fsm.sv
// Fan speed controller with a stepped auto-off timer (0/1/3/5 minutes).
// Speed buttons, a timer button and a countdown that turns the fan off when it expires.
//
// state   | meaning
// ST_OFF  | motor stopped, timer button ignored
// ST_LOW  | speed 1
// ST_MID  | speed 2
// ST_HIGH | speed 3
module fan_mode_fsm #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int SEC_PER_MIN = 60
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_button,
  output logic [2:0] o_motorState,
  output logic [2:0] o_fndState,
  output logic [2:0] o_timerMin,
  output logic       o_timerActive
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SEC_MAX   = SW'(SEC_PER_MIN - 1);

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_LOW  = 3'd1,
    ST_MID  = 3'd2,
    ST_HIGH = 3'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [2:0]    min_q, min_d;
  logic [SW-1:0] sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          active_q, active_d;
  logic [2:0]    fnd_q, fnd_d;

  logic btn_off, btn_low, btn_mid, btn_high, btn_tmr;
  logic tick, expire;

  // Selection index 0..3 maps onto 0, 1, 3, 5 minutes.
  function automatic logic [2:0] sel_minutes(input logic [1:0] idx);
    case (idx)
      2'd1:    sel_minutes = 3'd1;
      2'd2:    sel_minutes = 3'd3;
      2'd3:    sel_minutes = 3'd5;
      default: sel_minutes = 3'd0;
    endcase
  endfunction

  // Lowest-index button wins when several are pressed together.
  always_comb begin
    btn_off  = 1'b0;
    btn_low  = 1'b0;
    btn_mid  = 1'b0;
    btn_high = 1'b0;
    btn_tmr  = 1'b0;
    if (i_button[0])      btn_off  = 1'b1;
    else if (i_button[1]) btn_low  = 1'b1;
    else if (i_button[2]) btn_mid  = 1'b1;
    else if (i_button[3]) btn_high = 1'b1;
    else if (i_button[4]) btn_tmr  = 1'b1;
  end

  assign tick   = active_q && (presc_q == PRESC_MAX);
  assign expire = tick && (sec_q == '0) && (min_q <= 3'd1);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    min_d    = min_q;
    sec_d    = sec_q;
    presc_d  = presc_q;
    active_d = active_q;

    if (active_q) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    if (tick) begin
      if (sec_q != '0) begin
        sec_d = sec_q - SW'(1);
      end else if (min_q > 3'd1) begin
        min_d = min_q - 3'd1;
        sec_d = SEC_MAX;
      end else begin
        state_d  = ST_OFF;
        sel_d    = 2'd0;
        min_d    = 3'd0;
        sec_d    = '0;
        presc_d  = '0;
        active_d = 1'b0;
      end
    end

    // Expiry swallows any button pressed in the same cycle.
    if (!expire) begin
      if (btn_off) begin
        state_d  = ST_OFF;
        sel_d    = 2'd0;
        min_d    = 3'd0;
        sec_d    = '0;
        presc_d  = '0;
        active_d = 1'b0;
      end else if (btn_low) begin
        state_d = ST_LOW;
      end else if (btn_mid) begin
        state_d = ST_MID;
      end else if (btn_high) begin
        state_d = ST_HIGH;
      end else if (btn_tmr && (state_q != ST_OFF)) begin
        sel_d    = sel_q + 2'd1;
        min_d    = sel_minutes(sel_q + 2'd1);
        sec_d    = SEC_MAX;
        presc_d  = '0;
        active_d = (sel_q + 2'd1) != 2'd0;
      end
    end

    fnd_d = active_d ? min_d : state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_OFF;
      sel_q    <= 2'd0;
      min_q    <= 3'd0;
      sec_q    <= '0;
      presc_q  <= '0;
      active_q <= 1'b0;
      fnd_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      presc_q  <= presc_d;
      active_q <= active_d;
      fnd_q    <= fnd_d;
    end
  end

  assign o_motorState  = state_q;
  assign o_fndState    = fnd_q;
  assign o_timerMin    = min_q;
  assign o_timerActive = active_q;

endmodule

// File: tb/tb_fan_mode_fsm.sv
// Bench for fan_mode_fsm: cycle-count model of speed and remaining countdown time,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fan_mode_fsm;

  localparam int TD  = 4;
  localparam int SPM = 3;
  localparam int CYC_PER_MIN = TD * SPM;

  logic       clk;
  logic       rst;
  logic [4:0] button;
  logic [2:0] motor, fnd, tmin;
  logic       tact;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  // Model: speed plus remaining countdown cycles.
  int m_speed = 0;
  int m_sel   = 0;
  int m_rem   = 0;

  fan_mode_fsm #(.TICK_DIV(TD), .SEC_PER_MIN(SPM)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_button     (button),
    .o_motorState (motor),
    .o_fndState   (fnd),
    .o_timerMin   (tmin),
    .o_timerActive(tact)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_sel(input int s);
    case (s)
      0: next_sel = 1;
      1: next_sel = 3;
      3: next_sel = 5;
      default: next_sel = 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_speed = 0;
      m_sel   = 0;
      m_rem   = 0;
    end else begin
      bit expire;
      expire = (m_rem == 1);
      if (m_rem > 0) m_rem--;
      if (expire) begin
        m_speed = 0;
        m_sel   = 0;
      end else if (button[0]) begin
        m_speed = 0;
        m_sel   = 0;
        m_rem   = 0;
      end else if (button[1]) m_speed = 1;
      else if (button[2]) m_speed = 2;
      else if (button[3]) m_speed = 3;
      else if (button[4] && m_speed != 0) begin
        m_sel = next_sel(m_sel);
        m_rem = m_sel * CYC_PER_MIN;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int mmin;
      mmin = (m_rem + CYC_PER_MIN - 1) / CYC_PER_MIN;
      chk("model_motor",  motor, m_speed);
      chk("model_active", tact,  (m_rem > 0) ? 1 : 0);
      chk("model_min",    tmin,  mmin);
      chk("model_fnd",    fnd,   (m_rem > 0) ? mmin : m_speed);
    end
  end

  // Called at posedge+1; drives the pulse for one cycle, returns just after its capture edge.
  task automatic pulse(input logic [4:0] b);
    button = b;
    @(posedge clk); #1;
    button = 5'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1;
    button = 5'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_motor",  motor, 0);
    chk("reset_fnd",    fnd,   0);
    chk("reset_min",    tmin,  0);
    chk("reset_active", tact,  0);
    rst = 0;
    cmp_en = 1;

    // Speed select and priority
    pulse(5'b00100);
    chk("mid_select", motor, 2);
    pulse(5'b01010);
    chk("low_wins_high", motor, 1);
    pulse(5'b10010);
    chk("low_wins_timer_active", tact, 0);

    // Timer ignored in OFF
    pulse(5'b00001);
    chk("off_motor", motor, 0);
    pulse(5'b10000);
    chk("off_timer_ignored", tact, 0);
    chk("off_fnd", fnd, 0);

    // Timer stepping in HIGH
    pulse(5'b01000);
    chk("high_select", motor, 3);
    pulse(5'b10000);
    chk("step1_min", tmin, 1);
    chk("step1_fnd", fnd, 1);
    pulse(5'b10000);
    chk("step3_min", tmin, 3);
    chk("step3_fnd", fnd, 3);
    pulse(5'b10000);
    chk("step5_min", tmin, 5);
    chk("step5_fnd", fnd, 5);
    pulse(5'b10000);
    chk("step0_min", tmin, 0);
    chk("step0_active", tact, 0);
    chk("step0_fnd", fnd, 3);

    // 1-minute expiry in LOW, with HIGH pressed in the expiry cycle
    pulse(5'b00010);
    pulse(5'b10000);
    idle(11);
    chk("pre_expiry_active", tact, 1);
    chk("pre_expiry_motor", motor, 1);
    pulse(5'b01000);
    chk("expiry_motor", motor, 0);
    chk("expiry_active", tact, 0);
    chk("expiry_fnd", fnd, 0);
    idle(2);
    chk("post_expiry_motor", motor, 0);

    // Mid-countdown speed change, then OFF
    pulse(5'b01000);
    pulse(5'b10000);
    pulse(5'b10000);
    idle(5);
    pulse(5'b00100);
    chk("mid_cd_motor", motor, 2);
    chk("mid_cd_min", tmin, 3);
    chk("mid_cd_active", tact, 1);
    idle(10);
    chk("mid_cd_min_dec", tmin, 2);
    pulse(5'b00001);
    chk("mid_cd_off_motor", motor, 0);
    chk("mid_cd_off_min", tmin, 0);
    chk("mid_cd_off_active", tact, 0);

    // Re-stepping a running timer reloads it
    pulse(5'b00010);
    pulse(5'b10000);
    idle(7);
    pulse(5'b10000);
    chk("reload_min", tmin, 3);
    idle(20);

    // Reset during a 5-minute countdown, with a button held alongside
    pulse(5'b00001);
    pulse(5'b00010);
    pulse(5'b10000);
    pulse(5'b10000);
    pulse(5'b10000);
    chk("five_min_loaded", tmin, 5);
    idle(20);
    rst = 1;
    button = 5'b01000;
    @(posedge clk); #1;
    rst = 0;
    button = 5'b0;
    chk("rst_cd_motor", motor, 0);
    chk("rst_cd_fnd", fnd, 0);
    chk("rst_cd_min", tmin, 0);
    chk("rst_cd_active", tact, 0);
    idle(70);
    chk("rst_cd_no_expiry_motor", motor, 0);
    chk("rst_cd_no_expiry_active", tact, 0);

    // Full 5-minute countdown to expiry in MID
    pulse(5'b00100);
    pulse(5'b10000);
    pulse(5'b10000);
    pulse(5'b10000);
    idle(5 * CYC_PER_MIN - 1);
    chk("five_min_last_cycle", tact, 1);
    chk("five_min_last_min", tmin, 1);
    idle(1);
    chk("five_min_expired", motor, 0);
    chk("five_min_inactive", tact, 0);
    idle(3);

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fan_mode_fsm.md
FAN_MODE_FSM -- requirements
Module: fan_mode_fsm

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000, i_clk cycles per one-second tick.
REQ-002 Parameter SEC_PER_MIN, default 60, seconds per timer minute; tests override both parameters with small values.
REQ-003 i_clk  input  1  system clock; the only clock in the block.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_button  input  5  debounced single-cycle pulses: [0] OFF, [1] LOW, [2] MID, [3] HIGH, [4] TIMER.
REQ-006 o_motorState  output  3  speed select for the downstream duty mux: 0 OFF, 1 LOW, 2 MID, 3 HIGH; codes 4-7 are never driven.
REQ-007 o_fndState  output  3  display code: o_timerMin when o_timerActive is 1, otherwise o_motorState.
REQ-008 o_timerMin  output  3  remaining whole minutes; 0 when the timer is idle.
REQ-009 o_timerActive  output  1  1 while an auto-off countdown is running.
REQ-010 All outputs SHALL be registered, with no combinational path from i_button to any output.

Function
REQ-011 The speed FSM SHALL have states OFF, LOW, MID and HIGH, and o_motorState SHALL equal the state code.
REQ-012 If more than one i_button bit is high in a cycle, the lowest index SHALL win and the other bits are ignored.
REQ-013 A pulse on i_button[1..3] SHALL move the FSM to LOW, MID or HIGH from any state; pressing the current speed leaves the state unchanged.
REQ-014 i_button[0] SHALL move the FSM to OFF and clear the timer: o_timerMin=0, o_timerActive=0, and the prescaler and second counter are zeroed.
REQ-015 A button pulse in cycle N SHALL be visible on the outputs in cycle N+1 (1-cycle latency).
REQ-016 i_button[4] SHALL be ignored while the FSM is in OFF.
REQ-017 In any other state, i_button[4] SHALL step the timer selection 0 -> 1 -> 3 -> 5 -> 0 minutes.
REQ-018 Each i_button[4] step SHALL reload the countdown: minute counter = new selection, second counter = SEC_PER_MIN-1, prescaler = 0.
REQ-019 Selection 0 SHALL deactivate the timer and leave the FSM in its current speed.
REQ-020 The prescaler SHALL count 0..TICK_DIV-1 while o_timerActive=1, emitting one tick per wrap; it SHALL hold at 0 while the timer is idle.
REQ-021 On a tick with second counter > 0, the block SHALL decrement the second counter.
REQ-022 On a tick with second counter = 0 and o_timerMin > 1, the block SHALL decrement o_timerMin and reload the second counter to SEC_PER_MIN-1.
REQ-023 On a tick with second counter = 0 and o_timerMin = 1, the countdown SHALL expire: FSM -> OFF, o_timerMin=0, o_timerActive=0, selection -> 0.
REQ-024 If expiry coincides with any button pulse, expiry SHALL win and the button SHALL be ignored for that cycle.
REQ-025 Speed changes via i_button[1..3] SHALL NOT disturb a running countdown.
REQ-026 Counter widths SHALL be sized from TICK_DIV and SEC_PER_MIN with $clog2; counters SHALL never exceed their terminal value.
REQ-027 The countdown length SHALL be exactly sel*SEC_PER_MIN*TICK_DIV cycles from the cycle after the i_button[4] pulse to the expiry-driven OFF.

Reset
REQ-028 While i_reset=1 at a clock edge, the block SHALL go to: FSM OFF, o_motorState=0, o_fndState=0, o_timerMin=0, o_timerActive=0, selection 0, prescaler 0, second counter 0.
REQ-029 Reset SHALL override all button pulses and expiry in the same cycle, including reset during an active countdown.
REQ-030 The block SHALL return to normal operation on the first edge with i_reset=0.

Verification
REQ-031 Speed and priority: after reset, pulse [2] -> o_motorState=2 one cycle later; then pulse [3] and [1] together -> o_motorState=1.
REQ-032 Timer ignored in OFF: with the FSM in OFF, pulse [4] -> o_timerActive stays 0 and o_fndState=0.
REQ-033 Timer stepping (TICK_DIV=4, SEC_PER_MIN=3, state HIGH): pulse [4] four times -> o_timerMin reads 1, 3, 5, 0, and o_fndState tracks the timer value, then 3 after deactivation.
REQ-034 Expiry (same parameters, LOW, select 1 min): o_motorState=0 and o_timerActive=0 exactly 12 cycles after the pulse; a [3] pulse in the expiry cycle is ignored.
REQ-035 Mid-countdown events: with the 3-minute timer running, pulse [2] -> countdown continues and o_timerMin is unchanged; then pulse [0] -> OFF with o_timerMin=0.
REQ-036 Reset mid-countdown: assert i_reset during a 5-minute countdown -> all outputs are 0 on the next edge, and no expiry occurs afterward.
